gen12_packet_extractor: RTL and testbench
=========================================

// Module: gen12_packet_extractor
// PURPOSE
//  Downstream of the Gen1/2 packet identifier. Consumes its 64-lane beat (data plus per-lane framing markers) and strips framing.
//  TLP bytes go out as a masked, 1-cycle-delayed beat with start/end/nullify lane masks; DLLPs are assembled into a FIFO.
//  Feeds the DLL receive logic: LCRC check and DLLP decode.
// PARAMETERS
//  LANES       64  bytes per beat; data width = 8*LANES
//  DLLP_DEPTH  8   DLLP FIFO entries (power of 2, >= 2)
// PORTS
//  clk            in   1         sole clock
//  rst            in   1         asynchronous, active-high reset
//  data_in        in   8*LANES   beat from identifier (Data_out); lane i = data_in[8i+7:8i]
//  valid_d        in   LANES     lane holds a valid symbol
//  tlpstart       in   LANES     lane holds STP
//  tlpend         in   LANES     lane holds END closing a TLP
//  tlpedb         in   LANES     lane holds EDB (nullified TLP end)
//  dlpstart       in   LANES     lane holds SDP
//  dlpend         in   LANES     lane holds END closing a DLLP
//  tlp_data       out  8*LANES   data_in delayed 1 cycle
//  tlp_byte_en    out  LANES     lane is TLP payload (framing symbols excluded)
//  tlp_sop        out  LANES     first payload lane of a TLP
//  tlp_eop        out  LANES     last payload lane of a TLP (END-terminated)
//  tlp_nullify    out  LANES     last payload lane of an EDB-terminated TLP
//  tlp_abort      out  1         pulse: open TLP is broken and must be discarded
//  dllp_data      out  48        FIFO head: 6 DLLP bytes, first received byte in [47:40]
//  dllp_valid     out  1         FIFO non-empty
//  dllp_ready     in   1         pop on dllp_valid & dllp_ready
//  err_framing    out  1         pulse: framing-order violation in the beat
//  err_dllp       out  1         pulse: DLLP dropped (bad length or FIFO full)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO empty, partial DLLP discarded. Reset mid-packet drops the packet silently.
//  Lanes are walked 0..LANES-1 within a beat. State carries across beats: IDLE, IN_TLP, IN_DLLP(cnt 0..6).
//  Lanes with valid_d=0 are ignored: no state change, no byte count, byte_en=0.
//  IDLE: STP -> IN_TLP, next valid lane gets sop. SDP -> IN_DLLP cnt=0. Any END/EDB -> err_framing, stays IDLE.
//  IN_TLP: data lane -> byte_en=1. END -> previous payload lane gets eop -> IDLE. EDB -> that lane gets nullify -> IDLE.
//    If that previous payload lane lies in the prior beat, the flag is driven in this beat on lane 0 with byte_en=0 there.
//    STP/SDP in IN_TLP -> err_framing, tlp_abort, restart per the new symbol.
//  IN_DLLP: data lane stores byte cnt, cnt++. END with cnt==6 -> push 48 bits -> IDLE. END with cnt!=6 or cnt>6 -> err_dllp, drop -> IDLE.
//    STP/SDP in IN_DLLP -> err_framing, drop, restart.
//  Several TLPs/DLLPs per beat are allowed, including an END and the next STP/SDP in adjacent lanes.
//  DLLP FIFO: up to LANES/8 pushes per beat, in lane order. Pushes landing on a full FIFO (after same-cycle pop) are dropped, err_dllp=1.
//    dllp_data is registered; a push becomes visible the cycle after the beat is sampled. Pop and push in the same cycle are legal.
//  Latency: all tlp_* and err_* outputs are registered, 1 cycle after the input beat. Error pulses last 1 cycle.
//    Multiple errors in one beat produce a single pulse.
// CONFIGURATION
//  GEN12_EXTRACT_STATS_EN defined: adds out ports tlp_cnt[31:0], dllp_cnt[31:0], err_cnt[31:0].
//    Counters are saturating, reset to 0. They count END-terminated TLPs, pushed DLLPs, and err_framing|err_dllp pulses.
//  Undefined: the ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  Package gen12_rx_pkg: STP/SDP/END/EDB/PAD symbol localparams; state enum (IDLE, IN_TLP, IN_DLLP); DLLP_BYTES=6.
//  Sub-module gen12_dllp_fifo: multi-push (0..LANES/8 per cycle), single-pop FIFO, DLLP_DEPTH x 48.
//  Lane walk is a combinational for-loop over the registered state, with a single state register update per beat.
// TESTING
//  1 TLP in one beat: STP lane0, payload lanes1-12, END lane13 -> byte_en=0x1FFE, sop bit1, eop bit12.
//  2 TLP spanning beats: STP lane60, END lane2 of next beat -> sop bit61 in beat 1; eop bit1 in beat 2; byte_en continuous.
//  3 Two DLLPs in one beat: SDP lanes 0 and 8, END lanes 7 and 15 -> 2 FIFO entries, dllp_valid next cycle, pop order preserved.
//  4 Short DLLP: SDP lane0, END lane5 -> err_dllp=1 for 1 cycle, no push.
//  5 EDB: STP lane0, EDB lane9 -> nullify bit8, eop=0. STP inside an open TLP -> err_framing, tlp_abort.
//  6 FIFO full with dllp_ready=0 plus one more DLLP -> err_dllp, occupancy stays DLLP_DEPTH. Assert rst mid-TLP -> all outputs 0.

Source files
------------

// File: rtl/gen12_rx_pkg.sv
// Shared symbols, receive-state encoding and helpers for the Gen1/2 receive path.
package gen12_rx_pkg;

    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_EDB = 8'hFE;
    localparam logic [7:0] SYM_PAD = 8'hF7;

    localparam int DLLP_BYTES = 6;
    localparam int DLLP_W     = 8 * DLLP_BYTES;

    typedef enum logic [1:0] {
        IDLE,
        IN_TLP,
        IN_DLLP
    } rx_state_t;

    typedef logic [DLLP_W-1:0] dllp_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/gen12_dllp_fifo.sv
// Purpose: DLLP queue taking up to NPUSH lane-ordered pushes per cycle, one pop per cycle.
// Latency: a push is visible on pop_dat/pop_vld the cycle after it is presented.
// Backpressure: pushes beyond free space (after same-cycle pop) are refused; push_acc reports how many landed.
module gen12_dllp_fifo
    import gen12_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NPUSH = 8,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPUSH-1:0] push_vld,
    input  dllp_t            push_dat [NPUSH],
    output logic [PW-1:0]    push_acc,
    output dllp_t            pop_dat,
    output logic             pop_vld,
    input  logic             pop_rdy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    dllp_t            mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, space;
    logic             pop_en;
    logic [NPUSH-1:0] wr_en;

    assign pop_vld = (count != '0);
    assign pop_en  = pop_vld & pop_rdy;
    assign pop_dat = mem[rd_ptr];

    // push_vld is filled from slot 0 upward, so accepting the first 'space' slots keeps lane order
    always_comb begin
        space    = CW'(DEPTH) - count + CW'(pop_en);
        wr_en    = '0;
        push_acc = '0;
        for (int k = 0; k < NPUSH; k++) begin
            if (push_vld[k] && (k < int'(space))) begin
                wr_en[k] = 1'b1;
                push_acc = push_acc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
        end else begin
            for (int k = 0; k < NPUSH; k++) begin
                if (wr_en[k]) mem[wr_ptr + AW'(k)] <= push_dat[k];
            end
            wr_ptr <= wr_ptr + AW'(push_acc);
            if (pop_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_acc) - CW'(pop_en);
        end
    end

endmodule

// File: rtl/gen12_packet_extractor.sv
// Purpose: strip Gen1/2 framing; emit masked TLP beats and queue 6-byte DLLPs (GEN12_EXTRACT_STATS_EN adds counters).
// Latency: all tlp_*/err_* outputs registered, 1 cycle after the input beat; DLLPs visible 1 cycle after their beat.
// Backpressure: TLP path has none; DLLPs arriving on a full queue are dropped and flagged on err_dllp.
module gen12_packet_extractor
    import gen12_rx_pkg::*;
#(
    parameter int LANES      = 64,
    parameter int DLLP_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*LANES-1:0] data_in,
    input  logic [LANES-1:0]   valid_d,
    input  logic [LANES-1:0]   tlpstart,
    input  logic [LANES-1:0]   tlpend,
    input  logic [LANES-1:0]   tlpedb,
    input  logic [LANES-1:0]   dlpstart,
    input  logic [LANES-1:0]   dlpend,
    output logic [8*LANES-1:0] tlp_data,
    output logic [LANES-1:0]   tlp_byte_en,
    output logic [LANES-1:0]   tlp_sop,
    output logic [LANES-1:0]   tlp_eop,
    output logic [LANES-1:0]   tlp_nullify,
    output logic               tlp_abort,
    output logic [47:0]        dllp_data,
    output logic               dllp_valid,
    input  logic               dllp_ready,
    output logic               err_framing,
    output logic               err_dllp
`ifdef GEN12_EXTRACT_STATS_EN
    ,
    output logic [31:0]        tlp_cnt,
    output logic [31:0]        dllp_cnt,
    output logic [31:0]        err_cnt
`endif
);
    localparam int NPUSH = LANES / 8;
    localparam int PW    = $clog2(NPUSH + 1);
    localparam int LW    = $clog2(LANES);

    rx_state_t        st_q, st_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             sop_pend_q, sop_pend_d;
    logic             have_pay_q, have_pay_d;
    dllp_t            dbuf_q, dbuf_d;
    logic [LANES-1:0] be_d, sop_d, eop_d, nul_d;
    logic             abort_d, ferr_d, derr_d;
    logic [NPUSH-1:0] push_vld;
    dllp_t            push_dat [NPUSH];
    logic [PW-1:0]    n_req, push_acc;
`ifdef GEN12_EXTRACT_STATS_EN
    logic [7:0]       n_tlp;
`endif

    always_comb begin
        logic             last_in_beat;
        logic [LW-1:0]    last_lane;
        logic [LW-1:0]    flag_lane;
        logic [NPUSH-1:0] slot;
        last_in_beat = 1'b0;
        last_lane    = '0;
        flag_lane    = '0;
        slot         = NPUSH'(1);
        st_d         = st_q;
        cnt_d        = cnt_q;
        sop_pend_d   = sop_pend_q;
        have_pay_d   = have_pay_q;
        dbuf_d       = dbuf_q;
        be_d         = '0;
        sop_d        = '0;
        eop_d        = '0;
        nul_d        = '0;
        abort_d      = 1'b0;
        ferr_d       = 1'b0;
        derr_d       = 1'b0;
        push_vld     = '0;
        for (int k = 0; k < NPUSH; k++) push_dat[k] = '0;
`ifdef GEN12_EXTRACT_STATS_EN
        n_tlp        = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            if (valid_d[i]) begin
                if (tlpstart[i] || dlpstart[i]) begin
                    if (st_d != IDLE)   ferr_d  = 1'b1;
                    if (st_d == IN_TLP) abort_d = 1'b1;
                    if (tlpstart[i]) begin
                        st_d         = IN_TLP;
                        sop_pend_d   = 1'b1;
                        have_pay_d   = 1'b0;
                        last_in_beat = 1'b0;
                    end else begin
                        st_d  = IN_DLLP;
                        cnt_d = '0;
                    end
                end else if (tlpend[i] || tlpedb[i] || dlpend[i]) begin
                    // last payload in an earlier beat: its flag goes on lane 0 of this beat
                    flag_lane = last_in_beat ? last_lane : '0;
                    case (st_d)
                        IN_TLP: begin
                            if (!have_pay_d) begin
                                ferr_d = 1'b1;
                            end else if (tlpedb[i]) begin
                                nul_d[flag_lane] = 1'b1;
                            end else begin
                                eop_d[flag_lane] = 1'b1;
`ifdef GEN12_EXTRACT_STATS_EN
                                n_tlp = n_tlp + 8'd1;
`endif
                            end
                        end
                        IN_DLLP: begin
                            if (tlpedb[i]) begin
                                ferr_d = 1'b1;
                            end else if (cnt_d == 3'(DLLP_BYTES)) begin
                                for (int k = 0; k < NPUSH; k++) begin
                                    if (slot[k]) push_dat[k] = dbuf_d;
                                end
                                push_vld = push_vld | slot;
                                slot     = slot << 1;
                            end else begin
                                derr_d = 1'b1;
                            end
                        end
                        default: ferr_d = 1'b1;
                    endcase
                    st_d = IDLE;
                end else begin
                    case (st_d)
                        IN_TLP: begin
                            be_d[i] = 1'b1;
                            if (sop_pend_d) begin
                                sop_d[i]   = 1'b1;
                                sop_pend_d = 1'b0;
                            end
                            have_pay_d   = 1'b1;
                            last_lane    = LW'(i);
                            last_in_beat = 1'b1;
                        end
                        IN_DLLP: begin
                            if (cnt_d < 3'(DLLP_BYTES)) dbuf_d = {dbuf_d[DLLP_W-9:0], data_in[8*i +: 8]};
                            if (cnt_d != 3'd7) cnt_d = cnt_d + 3'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign n_req = PW'($countones(push_vld));

    gen12_dllp_fifo #(
        .DEPTH (DLLP_DEPTH),
        .NPUSH (NPUSH),
        .PW    (PW)
    ) u_dllp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .push_acc (push_acc),
        .pop_dat  (dllp_data),
        .pop_vld  (dllp_valid),
        .pop_rdy  (dllp_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            sop_pend_q  <= 1'b0;
            have_pay_q  <= 1'b0;
            dbuf_q      <= '0;
            tlp_data    <= '0;
            tlp_byte_en <= '0;
            tlp_sop     <= '0;
            tlp_eop     <= '0;
            tlp_nullify <= '0;
            tlp_abort   <= 1'b0;
            err_framing <= 1'b0;
            err_dllp    <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            sop_pend_q  <= sop_pend_d;
            have_pay_q  <= have_pay_d;
            dbuf_q      <= dbuf_d;
            tlp_data    <= data_in;
            tlp_byte_en <= be_d;
            tlp_sop     <= sop_d;
            tlp_eop     <= eop_d;
            tlp_nullify <= nul_d;
            tlp_abort   <= abort_d;
            err_framing <= ferr_d;
            err_dllp    <= derr_d | (push_acc != n_req);
        end
    end

`ifdef GEN12_EXTRACT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlp_cnt  <= '0;
            dllp_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            tlp_cnt  <= sat_add32(tlp_cnt, 32'(n_tlp));
            dllp_cnt <= sat_add32(dllp_cnt, 32'(push_acc));
            err_cnt  <= sat_add32(err_cnt, 32'(err_framing | err_dllp));
        end
    end
`endif

endmodule

// File: tb/tb_gen12_packet_extractor.sv
// Packet-level stream generator with expected per-lane flags, plus a queue model of the DLLP FIFO.
`timescale 1ns/1ps
module tb_gen12_packet_extractor;
    localparam int LANES = 64;
    localparam int DEPTH = 8;
    localparam int NB    = 400;
    localparam int TOT   = NB * LANES;
    localparam int K_DAT = 0, K_STP = 1, K_SDP = 2, K_TEND = 3, K_EDB = 4, K_DEND = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [8*LANES-1:0] data_in;
    logic [LANES-1:0]   valid_d, tlpstart, tlpend, tlpedb, dlpstart, dlpend;
    logic [8*LANES-1:0] tlp_data;
    logic [LANES-1:0]   tlp_byte_en, tlp_sop, tlp_eop, tlp_nullify;
    logic               tlp_abort, dllp_valid, dllp_ready, err_framing, err_dllp;
    logic [47:0]        dllp_data;
`ifdef GEN12_EXTRACT_STATS_EN
    logic [31:0]        tlp_cnt, dllp_cnt, err_cnt;
`endif

    always #5 clk = ~clk;

    gen12_packet_extractor #(.LANES(LANES), .DLLP_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .valid_d     (valid_d),
        .tlpstart    (tlpstart),
        .tlpend      (tlpend),
        .tlpedb      (tlpedb),
        .dlpstart    (dlpstart),
        .dlpend      (dlpend),
        .tlp_data    (tlp_data),
        .tlp_byte_en (tlp_byte_en),
        .tlp_sop     (tlp_sop),
        .tlp_eop     (tlp_eop),
        .tlp_nullify (tlp_nullify),
        .tlp_abort   (tlp_abort),
        .dllp_data   (dllp_data),
        .dllp_valid  (dllp_valid),
        .dllp_ready  (dllp_ready),
        .err_framing (err_framing),
`ifdef GEN12_EXTRACT_STATS_EN
        .tlp_cnt     (tlp_cnt),
        .dllp_cnt    (dllp_cnt),
        .err_cnt     (err_cnt),
`endif
        .err_dllp    (err_dllp)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Symbol stream and the expectations derived from packet boundaries
    logic [7:0] s_byte [TOT];
    bit         s_vld  [TOT];
    int         s_kind [TOT];
    bit         e_be [TOT], e_sop [TOT], e_eop [TOT], e_nul [TOT];
    bit         b_abort [NB], b_ferr [NB], b_derr [NB];
    typedef struct { int beat; logic [47:0] v; } push_t;
    push_t       pushes [$];
    logic [47:0] mq [$];
    int          p;
    bit          gaps_on, pend_tlp, pend_dllp;

    function automatic int put(input int kind);
        if (gaps_on) begin
            while ($urandom_range(0, 9) == 0) begin
                s_vld[p]  = 1'b0;
                s_kind[p] = int'($urandom_range(0, 5));
                s_byte[p] = 8'($urandom);
                p++;
            end
        end
        s_vld[p]  = 1'b1;
        s_kind[p] = kind;
        s_byte[p] = 8'($urandom);
        p++;
        return p - 1;
    endfunction

    task automatic start_item(input int kind);
        int q;
        q = put(kind);
        if (pend_tlp)  begin b_abort[q/LANES] = 1'b1; b_ferr[q/LANES] = 1'b1; end
        if (pend_dllp) b_ferr[q/LANES] = 1'b1;
        pend_tlp  = 1'b0;
        pend_dllp = 1'b0;
    endtask

    // endt: 0 = END, 1 = EDB, 2 = left open (broken by the next start)
    task automatic tlp_item(input int len, input int endt);
        int q, last;
        start_item(K_STP);
        last = 0;
        for (int k = 0; k < len; k++) begin
            q = put(K_DAT);
            e_be[q] = 1'b1;
            if (k == 0) e_sop[q] = 1'b1;
            last = q;
        end
        if (endt == 2) begin
            pend_tlp = 1'b1;
        end else begin
            q = put(endt == 1 ? K_EDB : K_TEND);
            if (q / LANES != last / LANES) last = (q / LANES) * LANES;
            if (endt == 1) e_nul[last] = 1'b1;
            else           e_eop[last] = 1'b1;
        end
    endtask

    task automatic dllp_item(input int n, input bit abrt);
        int q;
        logic [47:0] v;
        v = '0;
        start_item(K_SDP);
        for (int k = 0; k < n; k++) begin
            q = put(K_DAT);
            if (k < 6) v = {v[39:0], s_byte[q]};
        end
        if (abrt) begin
            pend_dllp = 1'b1;
        end else begin
            q = put(K_DEND);
            if (n == 6) pushes.push_back('{q / LANES, v});
            else        b_derr[q/LANES] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) void'(put(K_DAT));
    endtask

    initial begin
        int r, s, q;
        logic [LANES-1:0]   xbe, xsop, xeop, xnul;
        logic [8*LANES-1:0] xdata;
        bit                 xderr;

        rst = 1'b1;
        data_in = '0; valid_d = '0; tlpstart = '0; tlpend = '0; tlpedb = '0;
        dlpstart = '0; dlpend = '0; dllp_ready = 1'b0;

        // directed opening: lane-aligned examples, then randomized traffic with gaps
        p = 0; gaps_on = 1'b0; pend_tlp = 1'b0; pend_dllp = 1'b0;
        tlp_item(12, 0);                    // STP 0, payload 1..12, END 13
        idle(50);
        dllp_item(6, 1'b0); dllp_item(6, 1'b0);  // beat 1 lanes 0..15
        idle(44);
        tlp_item(5, 0);                     // STP beat1 lane60, END beat2 lane2
        idle(61);
        dllp_item(4, 1'b0);                 // SDP lane0, END lane5: too short
        idle(58);
        tlp_item(8, 1);                     // STP lane0, EDB lane9
        tlp_item(3, 2);
        tlp_item(2, 0);
        gaps_on = 1'b1;
        while (p < TOT - 300) begin
            r = int'($urandom_range(0, 99));
            s = int'($urandom_range(0, 99));
            if (r < 35) begin
                tlp_item(int'($urandom_range(1, 80)), (s < 70) ? 0 : (s < 85) ? 1 : 2);
            end else if (r < 75) begin
                dllp_item(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 6,
                          $urandom_range(0, 9) == 0);
            end else if (!pend_tlp && !pend_dllp) begin
                if (r < 85) begin
                    q = put(K_TEND + int'($urandom_range(0, 2)));
                    b_ferr[q/LANES] = 1'b1;
                end else begin
                    idle(int'($urandom_range(1, 20)));
                end
            end
        end
        if (pend_tlp || pend_dllp) tlp_item(4, 0);

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset byte_en", tlp_byte_en, '0);
        check_eq("reset data", tlp_data, '0);
        check_eq("reset dllp_valid", dllp_valid, 1'b0);
        check_eq("reset errors", {err_framing, err_dllp, tlp_abort}, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            for (int l = 0; l < LANES; l++) begin
                data_in[8*l +: 8] = s_byte[b*LANES + l];
                valid_d[l]  = s_vld[b*LANES + l];
                tlpstart[l] = (s_kind[b*LANES + l] == K_STP);
                dlpstart[l] = (s_kind[b*LANES + l] == K_SDP);
                tlpend[l]   = (s_kind[b*LANES + l] == K_TEND);
                tlpedb[l]   = (s_kind[b*LANES + l] == K_EDB);
                dlpend[l]   = (s_kind[b*LANES + l] == K_DEND);
            end
            case ((b / 40) % 3)
                0:       dllp_ready = ($urandom_range(0, 9) != 0);
                1:       dllp_ready = 1'b0;
                default: dllp_ready = ($urandom_range(0, 1) != 0);
            endcase
            @(posedge clk);
            if (mq.size() > 0 && dllp_ready) void'(mq.pop_front());
            xderr = b_derr[b];
            while (pushes.size() > 0 && pushes[0].beat == b) begin
                if (mq.size() < DEPTH) mq.push_back(pushes[0].v);
                else                   xderr = 1'b1;
                void'(pushes.pop_front());
            end
            for (int l = 0; l < LANES; l++) begin
                xdata[8*l +: 8] = s_byte[b*LANES + l];
                xbe[l]  = e_be[b*LANES + l];
                xsop[l] = e_sop[b*LANES + l];
                xeop[l] = e_eop[b*LANES + l];
                xnul[l] = e_nul[b*LANES + l];
            end
            #1;
            check_eq($sformatf("data b%0d", b), tlp_data, xdata);
            check_eq($sformatf("byte_en b%0d", b), tlp_byte_en, xbe);
            check_eq($sformatf("sop b%0d", b), tlp_sop, xsop);
            check_eq($sformatf("eop b%0d", b), tlp_eop, xeop);
            check_eq($sformatf("nullify b%0d", b), tlp_nullify, xnul);
            check_eq($sformatf("abort b%0d", b), tlp_abort, b_abort[b]);
            check_eq($sformatf("err_framing b%0d", b), err_framing, b_ferr[b]);
            check_eq($sformatf("err_dllp b%0d", b), err_dllp, xderr);
            check_eq($sformatf("dllp_valid b%0d", b), dllp_valid, mq.size() > 0);
            if (mq.size() > 0) check_eq($sformatf("dllp_data b%0d", b), dllp_data, mq[0]);
        end

        // reset in the middle of an open TLP
        @(negedge clk);
        valid_d = '1; tlpstart = 64'h1; tlpend = '0; tlpedb = '0; dlpstart = '0; dlpend = '0;
        data_in = {16{32'($urandom)}};
        @(posedge clk);
        #1;
        check_eq("pre-reset sop", tlp_sop, 64'h2);
        check_eq("pre-reset byte_en", tlp_byte_en, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid-tlp reset data", tlp_data, '0);
        check_eq("mid-tlp reset lanes", {tlp_byte_en, tlp_sop, tlp_eop, tlp_nullify}, '0);
        check_eq("mid-tlp reset dllp", {dllp_valid, dllp_data}, '0);
        check_eq("mid-tlp reset errors", {err_framing, err_dllp, tlp_abort}, 3'b000);
        valid_d = '0; tlpstart = '0;
        @(negedge clk);
        rst = 1'b0;
        valid_d = 64'h20; tlpend = 64'h20;
        @(posedge clk);
        #1;
        check_eq("post-reset END is stray", err_framing, 1'b1);
        check_eq("post-reset no eop", tlp_eop, '0);
        check_eq("post-reset no abort", tlp_abort, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
